hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage 16-bit processor; sits beside the forwarding unit and covers the hazards forwarding cannot resolve.
- Handles load-use stalls, taken-branch flushes and full-pipeline freezes while multi-cycle data memory is busy.
- Drives the PC and pipeline-register write-enables and flush/bubble controls.
- State and counters are registered; stage controls are a combinational decode of state plus current inputs, so a hazard is acted on in the cycle it is detected.

---
 rtl/hazard_stall_controller.sv | 186 ++++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use stall, branch flush and memory-freeze sequencing
// Optional macro STALL_COUNTER_EN enables the saturating stall_cycles counter.
module hazard_stall_controller #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IFIDrs,
  input  logic [REG_ADDR_W-1:0] IFIDrt,
  input  logic [REG_ADDR_W-1:0] IDEXrt,
  input  logic                  IDEXMemRead,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IFIDFlush,
  output logic                  IDEXBubble,
  output logic                  EXMEMWrite,
  output logic                  MEMWBWrite,
  output logic                  stall,
  output logic                  mem_timeout,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] LS_INIT     = 2'(LOAD_USE_STALLS - 1);
  localparam logic [8:0] TIMEOUT_CNT = 9'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_ls_cnt;
  logic [1:0] w_ls_cnt_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       r_mem_timeout;
  logic       w_mem_timeout_nxt;
  logic       r_ignore_busy;
  logic       w_ignore_busy_nxt;

  logic       w_busy;
  logic       w_luh;
  logic [8:0] w_wait_inc;
  logic       w_pc;
  logic       w_ifid;
  logic       w_flush;
  logic       w_bubble;
  logic       w_exmem;
  logic       w_memwb;
  logic       w_stall;

  // After a timeout the still-asserted busy line is masked until it drops.
  assign w_busy     = dmem_busy & ~r_ignore_busy;
  assign w_luh      = IDEXMemRead && (IDEXrt != '0) &&
                      ((IDEXrt == IFIDrs) || (IDEXrt == IFIDrt));
  assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

  always_comb begin
    w_next_state      = r_state;
    w_ls_cnt_nxt      = r_ls_cnt;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_timeout_nxt = r_mem_timeout;
    w_ignore_busy_nxt = r_ignore_busy & dmem_busy;
    w_pc              = 1'b1;
    w_ifid            = 1'b1;
    w_flush           = 1'b0;
    w_bubble          = 1'b0;
    w_exmem           = 1'b1;
    w_memwb           = 1'b1;
    w_stall           = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_busy) begin
          {w_pc, w_ifid, w_exmem, w_memwb} = 4'b0000;
          w_stall        = 1'b1;
          w_next_state   = S_MEM_WAIT;
          w_wait_cnt_nxt = 8'd1;
          w_ls_cnt_nxt   = 2'd0;
        end else if (branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_luh) begin
          w_pc     = 1'b0;
          w_ifid   = 1'b0;
          w_bubble = 1'b1;
          w_stall  = 1'b1;
          if (LOAD_USE_STALLS > 1) begin
            w_next_state = S_LOAD_STALL;
            w_ls_cnt_nxt = LS_INIT;
          end
        end
      end

      S_LOAD_STALL: begin
        if (w_busy) begin
          // Remaining bubble count is kept so the stall resumes after the freeze.
          {w_pc, w_ifid, w_exmem, w_memwb} = 4'b0000;
          w_stall        = 1'b1;
          w_next_state   = S_MEM_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end else begin
          w_pc         = 1'b0;
          w_ifid       = 1'b0;
          w_bubble     = 1'b1;
          w_stall      = 1'b1;
          w_ls_cnt_nxt = r_ls_cnt - 2'd1;
          if (r_ls_cnt <= 2'd1) begin
            w_next_state = S_RUN;
          end
        end
      end

      S_MEM_WAIT: begin
        {w_pc, w_ifid, w_exmem, w_memwb} = 4'b0000;
        w_stall = 1'b1;
        if (w_busy) begin
          if (w_wait_inc >= TIMEOUT_CNT) begin
            w_mem_timeout_nxt = 1'b1;
            w_ignore_busy_nxt = 1'b1;
            w_next_state      = S_RUN;
            w_wait_cnt_nxt    = 8'd0;
            w_ls_cnt_nxt      = 2'd0;
          end else if (r_wait_cnt != 8'hFF) begin
            w_wait_cnt_nxt = w_wait_inc[7:0];
          end
        end else begin
          w_wait_cnt_nxt = 8'd0;
          w_next_state   = (r_ls_cnt != 2'd0) ? S_LOAD_STALL : S_RUN;
        end
      end

      default: begin
        w_next_state = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_ls_cnt      <= 2'd0;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
      r_ignore_busy <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_ls_cnt      <= w_ls_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
      r_ignore_busy <= w_ignore_busy_nxt;
    end
  end

  assign PCWrite     = ~reset & w_pc;
  assign IFIDWrite   = ~reset & w_ifid;
  assign IFIDFlush   =  reset | w_flush;
  assign IDEXBubble  =  reset | w_bubble;
  assign EXMEMWrite  = ~reset & w_exmem;
  assign MEMWBWrite  = ~reset & w_memwb;
  assign stall       =  reset | w_stall;
  assign mem_timeout = ~reset & r_mem_timeout;

`ifdef STALL_COUNTER_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = reset ? 16'd0 : r_stall_cycles;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed checks for hazard_stall_controller
// Two instances share inputs: LOAD_USE_STALLS = 1 and LOAD_USE_STALLS = 3.
module tb_hazard_stall_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] IFIDrs, IFIDrt, IDEXrt;
  logic       IDEXMemRead, branch_taken, dmem_busy;

  logic        pc1, ifid1, fl1, bb1, ex1, mw1, st1, to1;
  logic        pc3, ifid3, fl3, bb3, ex3, mw3, st3, to3;
  logic [15:0] sc1, sc3;
  logic [6:0]  w_c1, w_c3;

  int checks = 0;
  int passed = 0;

  // Control vector order: PCWrite IFIDWrite IFIDFlush IDEXBubble EXMEMWrite MEMWBWrite stall
  localparam logic [6:0] C_RUN    = 7'b1100110;
  localparam logic [6:0] C_LUH    = 7'b0001111;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_RESET  = 7'b0011001;

`ifdef STALL_COUNTER_EN
  localparam logic [15:0] EXP_TO_STALLS = 16'd16;
`else
  localparam logic [15:0] EXP_TO_STALLS = 16'd0;
`endif

  always #5 clock = ~clock;

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .MEM_TIMEOUT(16)) u_dut1 (
    .clock(clock), .reset(reset), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IDEXrt(IDEXrt),
    .IDEXMemRead(IDEXMemRead), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .PCWrite(pc1), .IFIDWrite(ifid1), .IFIDFlush(fl1), .IDEXBubble(bb1),
    .EXMEMWrite(ex1), .MEMWBWrite(mw1), .stall(st1), .mem_timeout(to1), .stall_cycles(sc1)
  );

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .MEM_TIMEOUT(16)) u_dut3 (
    .clock(clock), .reset(reset), .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IDEXrt(IDEXrt),
    .IDEXMemRead(IDEXMemRead), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .PCWrite(pc3), .IFIDWrite(ifid3), .IFIDFlush(fl3), .IDEXBubble(bb3),
    .EXMEMWrite(ex3), .MEMWBWrite(mw3), .stall(st3), .mem_timeout(to3), .stall_cycles(sc3)
  );

  assign w_c1 = {pc1, ifid1, fl1, bb1, ex1, mw1, st1};
  assign w_c3 = {pc3, ifid3, fl3, bb3, ex3, mw3, st3};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ctl(input string tag, input logic [6:0] e1, input logic [6:0] e3);
    chk({tag, "_lus1"}, {9'd0, w_c1}, {9'd0, e1});
    chk({tag, "_lus3"}, {9'd0, w_c3}, {9'd0, e3});
  endtask

  task automatic drive(input logic rd, input logic [4:0] exrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic busy);
    IDEXMemRead  = rd;
    IDEXrt       = exrt;
    IFIDrs       = rs;
    IFIDrt       = rt;
    branch_taken = br;
    dmem_busy    = busy;
    #3;
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ctl("reset_ctl", C_RESET, C_RESET);
    chk("reset_timeout", {15'd0, to1}, 16'd0);
    chk("reset_stall_cycles", sc1, 16'd0);
    cyc();
    cyc();
    reset = 1'b0;

    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    ctl("idle", C_RUN, C_RUN);
    cyc();

    // load x5 then add with rs = 5
    drive(1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0);
    ctl("luh_c1", C_LUH, C_LUH);
    cyc();
    drive(1'b0, 5'd0, 5'd5, 5'd2, 1'b0, 1'b0);
    ctl("luh_c2", C_RUN, C_LUH);
    cyc();
    drive(1'b0, 5'd0, 5'd5, 5'd2, 1'b0, 1'b0);
    ctl("luh_c3", C_RUN, C_LUH);
    cyc();
    drive(1'b0, 5'd0, 5'd5, 5'd2, 1'b0, 1'b0);
    ctl("luh_done", C_RUN, C_RUN);
    cyc();

    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ctl("load_r0", C_RUN, C_RUN);
    cyc();

    // branch wins over a coincident load-use on rt
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    ctl("branch_luh", C_BRANCH, C_BRANCH);
    cyc();
    drive(1'b0, 5'd0, 5'd3, 5'd7, 1'b0, 1'b0);
    ctl("after_branch", C_RUN, C_RUN);
    cyc();

    // load-use with memory busy for two cycles during the stall
    drive(1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0);
    ctl("lsb_luh", C_LUH, C_LUH);
    cyc();
    drive(1'b0, 5'd0, 5'd9, 5'd1, 1'b0, 1'b1);
    ctl("lsb_busy1", C_FREEZE, C_FREEZE);
    cyc();
    drive(1'b0, 5'd0, 5'd9, 5'd1, 1'b0, 1'b1);
    ctl("lsb_busy2", C_FREEZE, C_FREEZE);
    cyc();
    drive(1'b0, 5'd0, 5'd9, 5'd1, 1'b0, 1'b0);
    ctl("lsb_fall", C_FREEZE, C_FREEZE);
    cyc();
    drive(1'b0, 5'd0, 5'd9, 5'd1, 1'b0, 1'b0);
    ctl("lsb_resume1", C_RUN, C_LUH);
    cyc();
    drive(1'b0, 5'd0, 5'd9, 5'd1, 1'b0, 1'b0);
    ctl("lsb_resume2", C_RUN, C_LUH);
    cyc();
    drive(1'b0, 5'd0, 5'd9, 5'd1, 1'b0, 1'b0);
    ctl("lsb_done", C_RUN, C_RUN);
    cyc();

    // clear the stall counter before the timeout run
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // dmem_busy held 20 cycles against MEM_TIMEOUT = 16
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      if (i == 16) begin
        ctl("to_last_freeze", C_FREEZE, C_FREEZE);
        chk("to_flag_pre", {15'd0, to1}, 16'd0);
      end
      if (i == 17) begin
        ctl("to_released", C_RUN, C_RUN);
        chk("to_flag_set", {15'd0, to1}, 16'd1);
      end
      if (i == 3) ctl("to_mid_freeze", C_FREEZE, C_FREEZE);
      if (i == 20) ctl("to_busy_ignored", C_RUN, C_RUN);
      cyc();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ctl("to_idle", C_RUN, C_RUN);
    chk("to_sticky", {15'd0, to3}, 16'd1);
    chk("to_stall_cycles", sc1, EXP_TO_STALLS);
    cyc();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    ctl("busy_rearmed", C_FREEZE, C_FREEZE);
    cyc();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ctl("busy_rearm_fall", C_FREEZE, C_FREEZE);
    cyc();

    // reset on the second cycle of a three-cycle load-use stall
    drive(1'b1, 5'd4, 5'd2, 5'd4, 1'b0, 1'b0);
    ctl("rst_luh", C_LUH, C_LUH);
    cyc();
    drive(1'b0, 5'd0, 5'd2, 5'd4, 1'b0, 1'b0);
    ctl("rst_stall2_pre", C_RUN, C_LUH);
    chk("rst_sticky_pre", {15'd0, to3}, 16'd1);
    reset = 1'b1;
    #1;
    ctl("rst_during", C_RESET, C_RESET);
    chk("rst_timeout_masked", {15'd0, to3}, 16'd0);
    chk("rst_stall_cycles", sc3, 16'd0);
    cyc();
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd2, 5'd4, 1'b0, 1'b0);
    ctl("rst_release", C_RUN, C_RUN);
    chk("rst_timeout_clear", {15'd0, to3}, 16'd0);
    chk("rst_sc_clear", sc3, 16'd0);
    cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
